// File: rtl/seq_bin_to_bcd_if.sv
// ---------------------------------------------------------------------------
// seq_bin_to_bcd_if
//   Handshake and data bundle between a requester and the sequential
//   binary-to-BCD converter.
//
//   Parameters
//     BIN_W   : binary input width
//     DIGITS  : number of BCD digits (result width 4*DIGITS)
//
//   Signals
//     start    : requester -> converter, request a conversion of bin_in
//     bin_in   : requester -> converter, value sampled when start is accepted
//     busy     : converter -> requester, high while shifting
//     done     : converter -> requester, one-cycle result-valid pulse
//     bcd_out  : converter -> requester, packed BCD, digit 0 in [3:0]
//     sign_out : converter -> requester, result is negative
//     overflow : converter -> requester, value did not fit in DIGITS digits
//
//   Modports
//     master : the requester side
//     slave  : the converter side
// ---------------------------------------------------------------------------
interface seq_bin_to_bcd_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) ();
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  sign_out;
    logic                  overflow;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out,
        input  sign_out,
        input  overflow
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out,
        output sign_out,
        output overflow
    );
endinterface

// File: rtl/seq_bin_to_bcd.sv
// ---------------------------------------------------------------------------
// seq_bin_to_bcd
//   Multi-cycle binary-to-BCD converter (shift-and-add-3 / double dabble),
//   one input bit per clock. A conversion accepted on edge E0 shifts on
//   edges E1..E_BIN_W and presents its result with a one-cycle done pulse
//   after E_BIN_W. Results are held in an output register that only
//   changes when a conversion completes, so partial values never appear.
//
//   Optional feature macro: SIGNED_INPUT_EN
//     defined   : bin_in is two's complement; its magnitude is converted
//                 and sign_out reports the sign.
//     undefined : bin_in is unsigned, sign_out is tied low and no
//                 negation logic exists.
//
//   Parameters
//     BIN_W  (>= 2) : input width
//     DIGITS        : BCD digits produced
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : seq_bin_to_bcd_if.slave
//              (start, bin_in in; busy, done, bcd_out, sign_out,
//               overflow out)
// ---------------------------------------------------------------------------
module seq_bin_to_bcd #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_bin_to_bcd_if.slave   bus
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [BIN_W-1:0]   shreg;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_acc;
    logic               sign_lat;

    logic               busy;
    logic               done;
    logic [ACC_W-1:0]   bcd_out;
    logic               sign_out;
    logic               overflow;

    logic [BIN_W-1:0]   mag_in;
    logic               sign_in;
    logic [ACC_W-1:0]   acc_adj;

    // Each digit >= 5 gets +3 before the shift so that the doubling carries
    // correctly into the next decimal digit. Digits are independent 4-bit
    // adds; a corrected digit never exceeds 4'hC, so nothing spills over.
    function automatic logic [ACC_W-1:0] add3_digits(input logic [ACC_W-1:0] acc_in);
        logic [ACC_W-1:0] res;
        res = acc_in;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc_in[4*d +: 4] >= 4'd5) begin
                res[4*d +: 4] = acc_in[4*d +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

`ifdef SIGNED_INPUT_EN
    // Negation is done in BIN_W-bit unsigned arithmetic, so the most
    // negative input maps onto its own bit pattern, which read unsigned is
    // exactly its magnitude 2^(BIN_W-1).
    assign sign_in = bus.bin_in[BIN_W-1];
    assign mag_in  = sign_in ? (BIN_W'(0) - bus.bin_in) : bus.bin_in;
`else
    assign sign_in = 1'b0;
    assign mag_in  = bus.bin_in;
`endif

    assign acc_adj = add3_digits(acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_acc  <= 1'b0;
            sign_lat <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            sign_out <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        shreg    <= mag_in;
                        sign_lat <= sign_in;
                        acc      <= '0;
                        ovf_acc  <= 1'b0;
                        cnt      <= CNT_W'(BIN_W);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                SHIFT: begin
                    // The top bit of the corrected accumulator leaves the
                    // register here; a 1 means the value needs more digits.
                    {acc, shreg} <= {acc_adj[ACC_W-2:0], shreg, 1'b0};
                    ovf_acc      <= ovf_acc | acc_adj[ACC_W-1];
                    cnt          <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        // Last shift: publish the post-shift accumulator.
                        bcd_out  <= {acc_adj[ACC_W-2:0], shreg[BIN_W-1]};
                        overflow <= ovf_acc | acc_adj[ACC_W-1];
                        sign_out <= sign_lat;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.bcd_out  = bcd_out;
    assign bus.sign_out = sign_out;
    assign bus.overflow = overflow;

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// ---------------------------------------------------------------------------
// tb_seq_bin_to_bcd
//   Directed bench for seq_bin_to_bcd. Instance a uses the defaults
//   (BIN_W=16, DIGITS=5); instance b uses BIN_W=10, DIGITS=3 for the
//   digit-overflow boundary. Signed expectations follow SIGNED_INPUT_EN.
// ---------------------------------------------------------------------------
module tb_seq_bin_to_bcd;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    seq_bin_to_bcd_if #(.BIN_W(16), .DIGITS(5)) a_if ();
    seq_bin_to_bcd_if #(.BIN_W(10), .DIGITS(3)) b_if ();

    seq_bin_to_bcd #(.BIN_W(16), .DIGITS(5)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    seq_bin_to_bcd #(.BIN_W(10), .DIGITS(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Start a conversion on instance a, optionally re-pulse start with v2
    // on cycle pulse_at (0 = never), and watch 24 cycles after the
    // accepting edge. bin_in is scrambled right after E0.
    task automatic run_a(input logic [15:0] v, input int pulse_at, input logic [15:0] v2,
                         output int lat, output int ndone, output int nbusy,
                         output logic [19:0] bcd, output logic sgn, output logic ovf);
        @(negedge clk);
        a_if.start  = 1'b1;
        a_if.bin_in = v;
        @(posedge clk); #1;
        a_if.start  = 1'b0;
        a_if.bin_in = v2;
        lat = 0; ndone = 0; nbusy = 0;
        bcd = '0; sgn = 1'b0; ovf = 1'b0;
        if (a_if.busy) nbusy++;
        for (int i = 1; i <= 24; i++) begin
            if (i == pulse_at) a_if.start = 1'b1;
            @(posedge clk); #1;
            a_if.start = 1'b0;
            if (a_if.busy) nbusy++;
            if (a_if.done) begin
                ndone++;
                if (lat == 0) begin
                    lat = i;
                    bcd = a_if.bcd_out;
                    sgn = a_if.sign_out;
                    ovf = a_if.overflow;
                end
            end
        end
    endtask

    task automatic run_b(input logic [9:0] v, output int lat,
                         output logic [11:0] bcd, output logic ovf);
        @(negedge clk);
        b_if.start  = 1'b1;
        b_if.bin_in = v;
        @(posedge clk); #1;
        b_if.start  = 1'b0;
        lat = 0; bcd = '0; ovf = 1'b0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (b_if.done) begin
                lat = i;
                bcd = b_if.bcd_out;
                ovf = b_if.overflow;
            end
        end
    endtask

    int          lat, ndone, nbusy, gap;
    logic [19:0] bcd;
    logic        sgn, ovf;
    logic [11:0] bcd_b;
    logic [19:0] exp_bcd;
    logic        exp_sgn;

    initial begin
        rst_n       = 1'b0;
        a_if.start  = 1'b0;
        a_if.bin_in = '0;
        b_if.start  = 1'b0;
        b_if.bin_in = '0;
        #12;
        check("rst_busy",  32'(a_if.busy),     32'd0);
        check("rst_done",  32'(a_if.done),     32'd0);
        check("rst_bcd",   32'(a_if.bcd_out),  32'd0);
        check("rst_sign",  32'(a_if.sign_out), 32'd0);
        check("rst_ovf",   32'(a_if.overflow), 32'd0);
        check("rst_bcd_b", 32'(b_if.bcd_out),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-scale unsigned
        run_a(16'hFFFF, 0, 16'h0000, lat, ndone, nbusy, bcd, sgn, ovf);
        check("fs_lat",   32'(lat),   32'd16);
        check("fs_ndone", 32'(ndone), 32'd1);
        check("fs_busy",  32'(nbusy), 32'd16);
        check("fs_bcd",   32'(bcd),   32'h65535);
        check("fs_ovf",   32'(ovf),   32'd0);
        check("fs_sign",  32'(sgn),   32'd0);

        // Zero, then a back-to-back conversion with start held through DONE
        @(negedge clk);
        a_if.start  = 1'b1;
        a_if.bin_in = 16'd0;
        @(posedge clk); #1;
        a_if.bin_in = 16'd12345;
        lat = 0;
        for (int i = 1; i <= 24 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (a_if.done) lat = i;
        end
        check("zero_lat", 32'(lat), 32'd16);
        check("zero_bcd", 32'(a_if.bcd_out), 32'd0);
        gap = 0;
        for (int i = 1; i <= 24 && gap == 0; i++) begin
            @(posedge clk); #1;
            a_if.start = 1'b0;
            if (a_if.done) gap = i;
        end
        check("b2b_gap", 32'(gap), 32'd17);
        check("b2b_bcd", 32'(a_if.bcd_out), 32'h12345);
        repeat (2) @(posedge clk);

        // Signed / unsigned interpretation of negative-looking patterns
`ifdef SIGNED_INPUT_EN
        exp_bcd = 20'h12345; exp_sgn = 1'b1;
`else
        exp_bcd = 20'h53191; exp_sgn = 1'b0;
`endif
        run_a(16'hCFC7, 0, 16'h1111, lat, ndone, nbusy, bcd, sgn, ovf);
        check("neg_bcd",  32'(bcd), 32'(exp_bcd));
        check("neg_sign", 32'(sgn), 32'(exp_sgn));
`ifdef SIGNED_INPUT_EN
        exp_sgn = 1'b1;
`else
        exp_sgn = 1'b0;
`endif
        run_a(16'h8000, 0, 16'h2222, lat, ndone, nbusy, bcd, sgn, ovf);
        check("min_bcd",  32'(bcd), 32'h32768);
        check("min_sign", 32'(sgn), 32'(exp_sgn));
        run_a(16'h7FFF, 0, 16'hFFFF, lat, ndone, nbusy, bcd, sgn, ovf);
        check("max_bcd",  32'(bcd), 32'h32767);
        check("max_sign", 32'(sgn), 32'd0);

        // Overflow boundary on the narrow instance
        run_b(10'd999, lat, bcd_b, ovf);
        check("b999_lat", 32'(lat),   32'd10);
        check("b999_bcd", 32'(bcd_b), 32'h999);
        check("b999_ovf", 32'(ovf),   32'd0);
        run_b(10'd1000, lat, bcd_b, ovf);
        check("b1000_ovf", 32'(ovf),   32'd1);
        check("b1000_bcd", 32'(bcd_b), 32'h000);
        run_b(10'd5, lat, bcd_b, ovf);
        check("b5_ovf", 32'(ovf),   32'd0);
        check("b5_bcd", 32'(bcd_b), 32'h005);

        // Start re-pulsed while busy
        run_a(16'd4321, 5, 16'd9876, lat, ndone, nbusy, bcd, sgn, ovf);
        check("sb_lat",   32'(lat),   32'd16);
        check("sb_ndone", 32'(ndone), 32'd1);
        check("sb_bcd",   32'(bcd),   32'h04321);

        // Reset in the middle of a conversion
        @(negedge clk);
        a_if.start  = 1'b1;
        a_if.bin_in = 16'd1234;
        @(posedge clk); #1;
        a_if.start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(a_if.busy),     32'd0);
        check("mrst_done", 32'(a_if.done),     32'd0);
        check("mrst_bcd",  32'(a_if.bcd_out),  32'd0);
        check("mrst_ovf",  32'(a_if.overflow), 32'd0);
        check("mrst_sign", 32'(a_if.sign_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (a_if.done) ndone++;
        end
        check("mrst_nodone", 32'(ndone), 32'd0);
        run_a(16'd42, 0, 16'hABCD, lat, ndone, nbusy, bcd, sgn, ovf);
        check("post_lat", 32'(lat), 32'd16);
        check("post_bcd", 32'(bcd), 32'h00042);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
